// File: rtl/vga_canvas.sv
// VGA raster generator with a GRID_N x GRID_N drawing canvas and a cursor overlay.
// The canvas is painted or erased under a brush, cleared by a one-bit-per-cycle sweep, and exported flat.
module vga_canvas #(
   parameter int H_SYNC      = 128,
   parameter int H_BACK      = 88,
   parameter int H_ACTIVE    = 800,
   parameter int H_FRONT     = 40,
   parameter int V_SYNC      = 4,
   parameter int V_BACK      = 23,
   parameter int V_ACTIVE    = 600,
   parameter int V_FRONT     = 1,
   parameter int GRID_N      = 32,
   parameter int CELL_SHIFT  = 4,
   parameter int CURSOR_SIZE = 8,
   parameter int BRUSH       = 1
) (
   input  logic                       clkVga,
   input  logic                       iRst,
   input  logic [10:0]                iCursorX,
   input  logic [10:0]                iCursorY,
   input  logic                       iDraw,
   input  logic                       iErase,
   input  logic                       iClear,
   output logic [3:0]                 oRed,
   output logic [3:0]                 oGreen,
   output logic [3:0]                 oBlue,
   output logic                       oHs,
   output logic                       oVs,
   output logic                       oFrameStart,
   output logic                       oBusy,
   output logic [GRID_N*GRID_N-1:0]   oImage
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int H_OFF   = H_SYNC + H_BACK;
   localparam int V_OFF   = V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int GW      = $clog2(GRID_N);
   localparam int IW      = 2 * GW;
   localparam int CELLS   = GRID_N * GRID_N;
   localparam int PW      = 12;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   logic [HW-1:0]    h_cnt_reg;
   logic [VW-1:0]    v_cnt_reg;
   state_t           state_reg;
   logic [IW-1:0]    clr_idx_reg;
   logic             busy_reg;
   logic [CELLS-1:0] image_reg;
   logic [CELLS-1:0] image_next;
   logic [CELLS-1:0] hit;

   // Raster counters
   always_ff @(posedge clkVga) begin
      if (iRst) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else if (h_cnt_reg == HW'(H_TOTAL - 1)) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= (v_cnt_reg == VW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + VW'(1);
      end else begin
         h_cnt_reg <= h_cnt_reg + HW'(1);
      end
   end

   logic          active;
   logic [PW-1:0] h_pos;
   logic [PW-1:0] v_pos;
   logic          in_cursor;
   logic          in_grid;
   logic [IW-1:0] pix_cell;
   logic [11:0]   rgb_next;

   assign active = (h_cnt_reg >= HW'(H_OFF)) && (h_cnt_reg < HW'(H_OFF + H_ACTIVE)) &&
                   (v_cnt_reg >= VW'(V_OFF)) && (v_cnt_reg < VW'(V_OFF + V_ACTIVE));
   assign h_pos  = PW'(h_cnt_reg) - PW'(H_OFF);
   assign v_pos  = PW'(v_cnt_reg) - PW'(V_OFF);

   assign in_cursor = (h_pos >= {1'b0, iCursorX}) &&
                      (h_pos <= ({1'b0, iCursorX} + PW'(CURSOR_SIZE))) &&
                      (v_pos >= {1'b0, iCursorY}) &&
                      (v_pos <= ({1'b0, iCursorY} + PW'(CURSOR_SIZE)));
   assign in_grid   = (h_pos < PW'(GRID_N << CELL_SHIFT)) && (v_pos < PW'(GRID_N << CELL_SHIFT));
   assign pix_cell  = {h_pos[CELL_SHIFT +: GW], v_pos[CELL_SHIFT +: GW]};

   always_comb begin
      rgb_next = 12'h000;
      if (active) begin
         if (in_cursor) begin
            if (iErase)     rgb_next = 12'h0F0;
            else if (iDraw) rgb_next = 12'h00F;
            else            rgb_next = 12'hF00;
         end else if (in_grid && image_reg[pix_cell]) begin
            rgb_next = 12'hF0F;
         end else begin
            rgb_next = 12'hFFF;
         end
      end
   end

   always_ff @(posedge clkVga) begin
      if (iRst) begin
         {oRed, oGreen, oBlue} <= 12'h000;
         oHs                   <= 1'b0;
         oVs                   <= 1'b0;
         oFrameStart           <= 1'b0;
      end else begin
         {oRed, oGreen, oBlue} <= rgb_next;
         oHs                   <= !(h_cnt_reg < HW'(H_SYNC));
         oVs                   <= !(v_cnt_reg < VW'(V_SYNC));
         oFrameStart           <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
      end
   end

   logic [10:0] cell_x;
   logic [10:0] cell_y;
   logic        target_ok;

   assign cell_x    = iCursorX >> CELL_SHIFT;
   assign cell_y    = iCursorY >> CELL_SHIFT;
   assign target_ok = (cell_x < 11'(GRID_N)) && (cell_y < 11'(GRID_N));

   // Each canvas bit decides for itself whether it lies under the brush; edge
   // neighbours simply never match, so nothing wraps or aliases.
   generate
      for (genvar gi = 0; gi < CELLS; gi++) begin : g_brush
         localparam int CX = gi / GRID_N;
         localparam int CY = gi % GRID_N;
         logic centre;
         logic plus;
         assign centre = (cell_x == 11'(CX)) && (cell_y == 11'(CY));
         assign plus   = ((cell_x == 11'(CX + 1)) && (cell_y == 11'(CY))) ||
                         ((CX > 0) && (cell_x == 11'(CX - 1)) && (cell_y == 11'(CY))) ||
                         ((cell_y == 11'(CY + 1)) && (cell_x == 11'(CX))) ||
                         ((CY > 0) && (cell_y == 11'(CY - 1)) && (cell_x == 11'(CX)));
         assign hit[gi] = target_ok && (centre || ((BRUSH != 0) && plus));
      end
   endgenerate

   always_comb begin
      image_next = image_reg;
      if (state_reg == S_CLEAR)
         image_next[clr_idx_reg] = 1'b0;
      else if (iErase)
         image_next = image_reg & ~hit;
      else if (iDraw)
         image_next = image_reg | hit;
   end

   always_ff @(posedge clkVga) begin
      if (iRst) begin
         state_reg   <= S_IDLE;
         clr_idx_reg <= '0;
         busy_reg    <= 1'b0;
         image_reg   <= '0;
      end else begin
         image_reg <= image_next;
         case (state_reg)
            S_IDLE: begin
               if (iClear) begin
                  state_reg   <= S_CLEAR;
                  clr_idx_reg <= '0;
                  busy_reg    <= 1'b1;
               end
            end
            S_CLEAR: begin
               clr_idx_reg <= clr_idx_reg + IW'(1);
               if (clr_idx_reg == IW'(CELLS - 1)) begin
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign oBusy  = busy_reg;
   assign oImage = image_reg;

endmodule

// File: tb/tb_vga_canvas.sv
// Directed bench for vga_canvas; a compact raster geometry keeps every frame short.
module tb_vga_canvas;
   localparam int HS = 4, HB = 3, HA = 40, HF = 2;
   localparam int VS = 2, VB = 2, VA = 30, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FRAME = HT * VT;
   localparam int HOFF = HS + HB;
   localparam int VOFF = VS + VB;
   localparam int N = 1024;

   logic          clk = 1'b0;
   logic          iRst, iDraw, iErase, iClear;
   logic [10:0]   iCursorX, iCursorY;
   logic [3:0]    oRed, oGreen, oBlue;
   logic          oHs, oVs, oFrameStart, oBusy;
   logic [N-1:0]  oImage;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_img;
   logic [N-1:0] ones;

   always #5 clk = ~clk;

   vga_canvas #(
      .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
   ) dut (
      .clkVga(clk), .iRst(iRst), .iCursorX(iCursorX), .iCursorY(iCursorY),
      .iDraw(iDraw), .iErase(iErase), .iClear(iClear),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oHs(oHs), .oVs(oVs),
      .oFrameStart(oFrameStart), .oBusy(oBusy), .oImage(oImage)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_img(input string tag, input logic [N-1:0] exp);
      int first;
      first = -1;
      for (int i = N - 1; i >= 0; i--)
         if (oImage[i] !== exp[i]) first = i;
      checks++;
      assert (oImage === exp) else begin
         errors++;
         $error("FAIL %s observed bits set=%0d expected bits set=%0d first differing bit=%0d",
                tag, $countones(oImage), $countones(exp), first);
      end
   endtask

   task automatic do_reset();
      iRst = 1'b1; iDraw = 1'b0; iErase = 1'b0; iClear = 1'b0;
      step(); step();
      iRst = 1'b0;
   endtask

   task automatic draw_at(input int x, input int y);
      iCursorX = 11'(x); iCursorY = 11'(y); iDraw = 1'b1;
      step();
      iDraw = 1'b0;
   endtask

   task automatic fill_all();
      for (int x = 0; x < 32; x++)
         for (int y = 0; y < 32; y++) begin
            iCursorX = 11'(x * 16); iCursorY = 11'(y * 16); iDraw = 1'b1;
            step();
         end
      iDraw = 1'b0;
   endtask

   // Waits for the next frame-start pulse, then advances to the sample showing pixel (x,y).
   task automatic goto_pixel(input int x, input int y);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         step();
         if (oFrameStart === 1'b1) found = 1'b1;
      end
      check("frame_start_seen", 32'(found), 32'd1);
      repeat ((y + VOFF) * HT + x + HOFF) step();
   endtask

   initial begin
      int hs_low, vs_low, fs_cnt, hs_bad, vs_bad, fs_bad, blank_bad, active_white;
      int h, v;
      ones = '1;
      iCursorX = 11'd0; iCursorY = 11'd0;
      do_reset();

      // Reset after prior draws
      draw_at(100, 50);
      iRst = 1'b1;
      step(); step();
      check_img("reset_image", '0);
      check("reset_busy", 32'(oBusy), 32'd0);
      check("reset_rgb", {20'd0, oRed, oGreen, oBlue}, 32'h000);
      check("reset_hs", 32'(oHs), 32'd0);
      check("reset_vs", 32'(oVs), 32'd0);
      check("reset_fs", 32'(oFrameStart), 32'd0);
      iRst = 1'b0;
      step();
      check("first_fs", 32'(oFrameStart), 32'd1);
      check("first_hs", 32'(oHs), 32'd0);

      // Two free-running frames against a raster position model
      hs_low = 0; vs_low = 0; fs_cnt = 0; hs_bad = 0; vs_bad = 0; fs_bad = 0;
      blank_bad = 0; active_white = 0;
      for (int j = 0; j < 2 * FRAME; j++) begin
         h = j % HT;
         v = (j / HT) % VT;
         if (oHs === 1'b0) hs_low++;
         if (oVs === 1'b0) vs_low++;
         if (oFrameStart === 1'b1) fs_cnt++;
         if (oHs !== (h >= HS)) hs_bad++;
         if (oVs !== (v >= VS)) vs_bad++;
         if (oFrameStart !== (j % FRAME == 0)) fs_bad++;
         if (h >= HOFF && h < HOFF + HA && v >= VOFF && v < VOFF + VA) begin
            if ({oRed, oGreen, oBlue} === 12'hFFF) active_white++;
         end else if ({oRed, oGreen, oBlue} !== 12'h000) begin
            blank_bad++;
         end
         step();
      end
      check("hs_low_count", 32'(hs_low), 32'(2 * VT * HS));
      check("vs_low_count", 32'(vs_low), 32'(2 * VS * HT));
      check("fs_count", 32'(fs_cnt), 32'd2);
      check("hs_phase", 32'(hs_bad), 32'd0);
      check("vs_phase", 32'(vs_bad), 32'd0);
      check("fs_phase", 32'(fs_bad), 32'd0);
      check("blank_rgb", 32'(blank_bad), 32'd0);
      check("active_white", 32'(active_white), 32'(2 * HA * VA));
      check("fs_period", 32'(oFrameStart), 32'd1);

      // Plus brush at cell (6,3)
      do_reset();
      draw_at(100, 50);
      exp_img = '0;
      exp_img[195] = 1'b1; exp_img[163] = 1'b1; exp_img[227] = 1'b1;
      exp_img[194] = 1'b1; exp_img[196] = 1'b1;
      check_img("plus_draw", exp_img);

      // Corner clipping and erase priority
      do_reset();
      draw_at(0, 0);
      exp_img = '0;
      exp_img[0] = 1'b1; exp_img[1] = 1'b1; exp_img[32] = 1'b1;
      check_img("corner_draw", exp_img);
      iErase = 1'b1;
      draw_at(0, 0);
      iErase = 1'b0;
      check_img("erase_wins", '0);
      draw_at(0, 496);
      exp_img = '0;
      exp_img[31] = 1'b1; exp_img[30] = 1'b1; exp_img[63] = 1'b1;
      check_img("bottom_edge", exp_img);
      draw_at(600, 100);
      check_img("outside_600", exp_img);
      draw_at(512, 100);
      check_img("outside_512", exp_img);
      draw_at(496, 0);
      exp_img[992] = 1'b1; exp_img[960] = 1'b1; exp_img[993] = 1'b1;
      check_img("right_edge", exp_img);

      // Clear sweep with draw and clear held throughout
      do_reset();
      fill_all();
      check_img("fill_all", ones);
      iCursorX = 11'd0; iCursorY = 11'd0;
      iDraw = 1'b1; iClear = 1'b1;
      step();
      check("clear_busy_start", 32'(oBusy), 32'd1);
      check_img("clear_start_img", ones);
      for (int k = 0; k < N; k++) begin
         step();
         exp_img = ones << (k + 1);
         check_img($sformatf("sweep_bit%0d", k), exp_img);
         check($sformatf("sweep_busy%0d", k), 32'(oBusy), 32'(k < N - 1));
      end
      iDraw = 1'b0;
      step();
      check("clear_reaccept", 32'(oBusy), 32'd1);
      check_img("clear_reaccept_img", '0);
      iClear = 1'b0;

      // Reset in the middle of a sweep
      do_reset();
      fill_all();
      iClear = 1'b1;
      step();
      iClear = 1'b0;
      repeat (500) step();
      check_img("sweep_500", ones << 500);
      iRst = 1'b1;
      step();
      check("midclear_busy", 32'(oBusy), 32'd0);
      check_img("midclear_img", '0);
      iRst = 1'b0;

      // Pixel colours: cell (1,1) plus neighbours set, cursor box at (30,5)
      draw_at(20, 20);
      iCursorX = 11'd30; iCursorY = 11'd5;
      goto_pixel(20, 20);
      check("pix_cell11", {20'd0, oRed, oGreen, oBlue}, 32'hF0F);
      goto_pixel(30, 14);
      check("pix_cell10", {20'd0, oRed, oGreen, oBlue}, 32'hF0F);
      goto_pixel(5, 5);
      check("pix_white", {20'd0, oRed, oGreen, oBlue}, 32'hFFF);
      goto_pixel(32, 8);
      check("pix_cursor_red", {20'd0, oRed, oGreen, oBlue}, 32'hF00);
      goto_pixel(38, 13);
      check("pix_cursor_corner", {20'd0, oRed, oGreen, oBlue}, 32'hF00);
      goto_pixel(39, 13);
      check("pix_past_cursor", {20'd0, oRed, oGreen, oBlue}, 32'hFFF);
      iDraw = 1'b1;
      goto_pixel(32, 8);
      check("pix_cursor_blue", {20'd0, oRed, oGreen, oBlue}, 32'h00F);
      iErase = 1'b1;
      goto_pixel(32, 8);
      check("pix_cursor_green", {20'd0, oRed, oGreen, oBlue}, 32'h0F0);
      iDraw = 1'b0; iErase = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
